dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port word-addressed DMEM. It shares DMEM between port A (CPU load/store stage) and port B (loader/debug DMA). It grants one transfer per cycle with round-robin on contention, and supports a lock for atomic read-modify-write sequences. It drives DMEM's write-enable, address and write-data and registers read data back to the winning port.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DMEM.
// Round-robin on contention, with per-port lock for atomic read-modify-write sequences.
// Read data and error pulses are registered back to the port that won the transfer.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LOCK_TMO = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              b_err,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_idata,
  input  logic [DATA_W-1:0] mem_odata
);

  localparam logic MemSave = 1'b1;
  localparam logic MemLoad = 1'b0;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [4:0]      TmoLim   = 5'(LOCK_TMO);

  typedef enum logic [1:0] {StIdle, StLockA, StLockB} state_e;

  state_e      state;
  logic        last;      // 1 = B won the most recent transfer
  logic [3:0]  tmo_cnt;

  logic              a_xfer, b_xfer, any_xfer;
  logic              sel_we, sel_lock, in_range, tmo_expire;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grant decode; nothing is granted while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        StIdle: begin
          if (a_req && b_req) begin
            a_gnt = last;
            b_gnt = !last;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        StLockA: a_gnt = a_req;
        StLockB: b_gnt = b_req;
        default: begin
          a_gnt = 1'b0;
          b_gnt = 1'b0;
        end
      endcase
    end
  end

  assign a_xfer   = a_req & a_gnt;
  assign b_xfer   = b_req & b_gnt;
  assign any_xfer = a_xfer | b_xfer;

  // Select the winning port's request fields; zero when idle.
  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (a_xfer) begin
      sel_we    = a_we;
      sel_lock  = a_lock;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end else if (b_xfer) begin
      sel_we    = b_we;
      sel_lock  = b_lock;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  assign in_range   = {1'b0, sel_addr} < DepthExt;
  // Release fires on the edge that ends the LOCK_TMO-th idle cycle of a lock.
  assign tmo_expire = ({1'b0, tmo_cnt} + 5'd1) >= TmoLim;

  // DMEM drive: out-of-range writes are demoted to loads.
  always_comb begin
    mem_addr  = sel_addr;
    mem_idata = sel_wdata;
    mem_wena  = (any_xfer && sel_we && in_range) ? MemSave : MemLoad;
  end

  // Lock FSM, round-robin pointer and lock timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      last    <= 1'b1;
      tmo_cnt <= 4'd0;
    end else if (any_xfer) begin
      last    <= b_xfer;
      tmo_cnt <= 4'd0;
      if (sel_lock) begin
        state <= a_xfer ? StLockA : StLockB;
      end else begin
        state <= StIdle;
      end
    end else if (state != StIdle) begin
      if (tmo_expire) begin
        state   <= StIdle;
        tmo_cnt <= 4'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 4'd1;
      end
    end
  end

  // Read return and error pulses; rdata holds across writes and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      a_rvalid <= a_xfer & !sel_we;
      a_err    <= a_xfer & !in_range;
      b_rvalid <= b_xfer & !sel_we;
      b_err    <= b_xfer & !in_range;
      if (a_xfer && !sel_we) begin
        a_rdata <= in_range ? mem_odata : '0;
      end
      if (b_xfer && !sel_we) begin
        b_rdata <= in_range ? mem_odata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word DMEM model.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_wena;
  logic [31:0] mem_addr, mem_idata, mem_odata;

  int checks = 0;
  int errors = 0;

  // DMEM model: writes at negedge with truncated address, async read.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(negedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wena) mem[mem_addr[9:0]] <= mem_idata;
  end

  assign mem_odata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'hBAD0BAD0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_err(b_err),
    .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_idata(mem_idata), .mem_odata(mem_odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] addr, input logic [31:0] data);
    pl_addr = addr;
    pl_data = data;
    pl_en   = 1'b1;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    a_req = 1; b_req = 1; a_we = 1; a_addr = 32'd4;
    #1;
    checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got a=%b b=%b want 0 0", a_gnt, b_gnt);
    end
    checks++;
    if (mem_wena !== 1'b0) begin
      errors++; $display("FAIL reset_wena got %b want 0", mem_wena);
    end
    tick();
    checks++;
    if (a_rvalid !== 0 || b_rvalid !== 0 || a_err !== 0 || b_err !== 0) begin
      errors++; $display("FAIL reset_pulses got %b%b%b%b want 0000",
                         a_rvalid, b_rvalid, a_err, b_err);
    end
    checks++;
    if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata got %h %h want 0 0", a_rdata, b_rdata);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_read();
    do_reset();
    a_req = 1; a_addr = 32'd5;
    #1;
    checks++;
    if (a_gnt !== 1 || b_gnt !== 0 || mem_addr !== 32'd5 || mem_wena !== 0) begin
      errors++; $display("FAIL single_gnt got a=%b b=%b addr=%0d wena=%b want 1 0 5 0",
                         a_gnt, b_gnt, mem_addr, mem_wena);
    end
    tick();
    a_req = 0;
    #1;
    checks++;
    if (a_rvalid !== 1 || a_rdata !== 32'hDEADBEEF || b_gnt !== 0) begin
      errors++; $display("FAIL single_rdata got v=%b d=%h bg=%b want 1 deadbeef 0",
                         a_rvalid, a_rdata, b_gnt);
    end
    tick();
    checks++;
    if (a_rvalid !== 0) begin
      errors++; $display("FAIL single_pulse got %b want 0", a_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    do_reset();
    a_req = 1; a_addr = 32'd1;
    b_req = 1; b_addr = 32'd2;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++;
      if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
        errors++; $display("FAIL rr_gnt%0d got a=%b b=%b want %b %b",
                           i, a_gnt, b_gnt, exp_a, !exp_a);
      end
      tick();
      checks++;
      if (a_rvalid !== exp_a || b_rvalid !== !exp_a) begin
        errors++; $display("FAIL rr_rvalid%0d got a=%b b=%b want %b %b",
                           i, a_rvalid, b_rvalid, exp_a, !exp_a);
      end
    end
    checks++;
    if (a_rdata !== 32'h11 || b_rdata !== 32'h22) begin
      errors++; $display("FAIL rr_rdata got %h %h want 11 22", a_rdata, b_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    b_req = 1; b_lock = 1; b_addr = 32'd7;
    #1;
    checks++;
    if (b_gnt !== 1) begin
      errors++; $display("FAIL lock_first got %b want 1", b_gnt);
    end
    tick();
    b_req = 0; b_lock = 0;
    a_req = 1; a_addr = 32'd0;
    checks++;
    if (b_rvalid !== 1 || b_rdata !== 32'h77) begin
      errors++; $display("FAIL lock_read got v=%b d=%h want 1 77", b_rvalid, b_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_gnt !== 0) begin
        errors++; $display("FAIL lock_hold%0d got a_gnt=%b want 0", i, a_gnt);
      end
      tick();
    end
    b_req = 1; b_we = 1; b_wdata = 32'h55;
    #1;
    checks++;
    if (b_gnt !== 1 || a_gnt !== 0 || mem_wena !== 1) begin
      errors++; $display("FAIL lock_write got b=%b a=%b wena=%b want 1 0 1",
                         b_gnt, a_gnt, mem_wena);
    end
    tick();
    b_req = 0; b_we = 0;
    #1;
    checks++;
    if (a_gnt !== 1 || b_rvalid !== 0) begin
      errors++; $display("FAIL lock_release got a=%b brv=%b want 1 0", a_gnt, b_rvalid);
    end
    checks++;
    if (mem[7] !== 32'h55) begin
      errors++; $display("FAIL lock_mem7 got %h want 55", mem[7]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    b_req = 1; b_lock = 1; b_addr = 32'd3;
    tick();
    b_req = 0; b_lock = 0;
    a_req = 1; a_addr = 32'd3;
    for (int c = 1; c <= 15; c++) begin
      #1;
      checks++;
      if (a_gnt !== 0) begin
        errors++; $display("FAIL tmo_hold cycle %0d got a_gnt=%b want 0", c, a_gnt);
      end
      tick();
    end
    #1;
    checks++;
    if (a_gnt !== 1) begin
      errors++; $display("FAIL tmo_release cycle 16 got a_gnt=%b want 1", a_gnt);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    a_req = 1; a_addr = 32'd5;
    tick();
    a_we = 1; a_addr = 32'd2000; a_wdata = 32'hFFFF;
    #1;
    checks++;
    if (a_gnt !== 1 || mem_wena !== 0) begin
      errors++; $display("FAIL oor_wr got gnt=%b wena=%b want 1 0", a_gnt, mem_wena);
    end
    tick();
    a_we = 0;
    checks++;
    if (a_err !== 1 || a_rvalid !== 0 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL oor_wr_err got err=%b v=%b d=%h want 1 0 deadbeef",
                         a_err, a_rvalid, a_rdata);
    end
    checks++;
    if (mem[976] !== 32'h00C0FFEE) begin
      errors++; $display("FAIL oor_nowrite got %h want 00c0ffee", mem[976]);
    end
    tick();
    a_req = 0;
    checks++;
    if (a_err !== 1 || a_rvalid !== 1 || a_rdata !== 32'd0) begin
      errors++; $display("FAIL oor_rd got err=%b v=%b d=%h want 1 1 0",
                         a_err, a_rvalid, a_rdata);
    end
    tick();
    checks++;
    if (a_err !== 0) begin
      errors++; $display("FAIL oor_pulse got %b want 0", a_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_req = 1; a_we = 1; a_addr = 32'd9; a_wdata = 32'h1234;
    #1;
    checks++;
    if (mem_wena !== 1 || mem_addr !== 32'd9 || mem_idata !== 32'h1234) begin
      errors++; $display("FAIL b2b_drive got wena=%b addr=%0d data=%h want 1 9 1234",
                         mem_wena, mem_addr, mem_idata);
    end
    tick();
    a_we = 0;
    checks++;
    if (a_rvalid !== 0) begin
      errors++; $display("FAIL b2b_wr_rvalid got %b want 0", a_rvalid);
    end
    tick();
    a_req = 0;
    checks++;
    if (a_rvalid !== 1 || a_rdata !== 32'h1234) begin
      errors++; $display("FAIL b2b_raw got v=%b d=%h want 1 1234", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    b_req = 1; b_lock = 1; b_addr = 32'd1;
    tick();
    b_we = 1; b_addr = 32'd8; b_wdata = 32'h99;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_gnt !== 0 || a_gnt !== 0 || mem_wena !== 0) begin
      errors++; $display("FAIL rst_lock_gnt got b=%b a=%b wena=%b want 0 0 0",
                         b_gnt, a_gnt, mem_wena);
    end
    tick();
    checks++;
    if (b_rvalid !== 0 || mem[8] !== 32'h88) begin
      errors++; $display("FAIL rst_lock_suppress got rv=%b mem8=%h want 0 88",
                         b_rvalid, mem[8]);
    end
    rst_n = 1'b1;
    b_we = 0; b_lock = 0; b_addr = 32'd2;
    a_req = 1; a_addr = 32'd1;
    #1;
    checks++;
    if (a_gnt !== 1 || b_gnt !== 0) begin
      errors++; $display("FAIL rst_lock_idle got a=%b b=%b want 1 0", a_gnt, b_gnt);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd1, 32'h11);
    preload(10'd2, 32'h22);
    preload(10'd3, 32'h33);
    preload(10'd7, 32'h77);
    preload(10'd8, 32'h88);
    preload(10'd9, 32'h0);
    preload(10'd976, 32'h00C0FFEE);
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_timeout();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
